// File: rtl/exp_sum.sv
// exp_sum: softmax numerator stage. Re-streams a vector against its latched max,
// emits e^(x - max) in Q16.16 and accumulates the softmax denominator.
module exp_sum #(
  parameter int DW       = 32,
  parameter int N        = 32,
  parameter int LUT_BITS = 6,
  parameter int SW       = DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] max_in,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic [DW-1:0] exp_out,
  output logic          exp_valid,
  output logic [SW-1:0] sum_out,
  output logic          done
);

  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int LB6 = (LUT_BITS < 6) ? LUT_BITS : 6;
  // Narrower tables are the even-spaced subset of the 64-entry table.
  localparam logic [5:0] IDX_MASK = 6'(6'h3F << (6 - LB6));
  localparam logic signed [63:0] LOG2E = 64'sd94548;

  // round(65536 * 2^(i/64))
  localparam logic [16:0] LUT [64] = '{
    17'd65536,  17'd66250,  17'd66971,  17'd67700,  17'd68438,  17'd69183,  17'd69936,  17'd70698,
    17'd71468,  17'd72246,  17'd73032,  17'd73828,  17'd74632,  17'd75444,  17'd76266,  17'd77096,
    17'd77936,  17'd78785,  17'd79642,  17'd80510,  17'd81386,  17'd82273,  17'd83169,  17'd84074,
    17'd84990,  17'd85915,  17'd86851,  17'd87796,  17'd88752,  17'd89719,  17'd90696,  17'd91684,
    17'd92682,  17'd93691,  17'd94711,  17'd95743,  17'd96785,  17'd97839,  17'd98905,  17'd99982,
    17'd101070, 17'd102171, 17'd103283, 17'd104408, 17'd105545, 17'd106694, 17'd107856, 17'd109031,
    17'd110218, 17'd111418, 17'd112631, 17'd113858, 17'd115098, 17'd116351, 17'd117618, 17'd118899,
    17'd120194, 17'd121502, 17'd122825, 17'd124163, 17'd125515, 17'd126882, 17'd128263, 17'd129660
  };

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [1:0]    drain_cnt;
  logic [DW-1:0] m_q;
  logic          accept;

  logic                v1, v2, v3;
  logic signed [DW:0]  d_full, d1;
  logic signed [63:0]  d_ext, prod, t2, kneg;
  logic                zero3;
  logic [4:0]          k3;
  logic [5:0]          idx3;
  logic [DW-1:0]       lut_word, exp_n;

  assign accept = (state == RUN) && din_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && cnt == CW'(N - 1)) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    d_full   = $signed({din[DW-1], din}) - $signed({m_q[DW-1], m_q});
    d_ext    = {{(63 - DW){d1[DW]}}, d1};
    prod     = d_ext * LOG2E;
    kneg     = t2 >>> 16;
    lut_word = DW'(LUT[idx3]);
    exp_n    = zero3 ? '0 : (lut_word >> k3);
  end

  // Stage 3 splits into a k/idx register and the exp_out register so that
  // exp_valid lands three cycles after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      drain_cnt <= '0;
      m_q       <= '0;
      done      <= 1'b0;
      sum_out   <= '0;
      exp_out   <= '0;
      exp_valid <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      d1        <= '0;
      t2        <= '0;
      zero3     <= 1'b0;
      k3        <= '0;
      idx3      <= '0;
    end else begin
      done      <= (state == DONE);
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (state == IDLE && start) begin
        m_q <= max_in;
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end

      v1 <= accept;
      d1 <= (!d_full[DW] && |d_full) ? '0 : d_full;
      v2 <= v1;
      t2 <= prod >>> 16;
      v3    <= v2;
      zero3 <= (kneg < -64'sd16);
      k3    <= 5'(-kneg);
      idx3  <= t2[15:10] & IDX_MASK;

      exp_valid <= v3;
      if (v3) exp_out <= exp_n;
      if (state == IDLE && start) sum_out <= '0;
      else if (v3)                sum_out <= sum_out + SW'(exp_n);
    end
  end

endmodule

// File: tb/tb_exp_sum.sv
// Directed bench for exp_sum: streams hand-built vectors and compares each
// exp_out, its timing, the done pulse and sum_out against hand-computed values.
module tb_exp_sum;

  localparam int DW   = 32;
  localparam int N    = 32;
  localparam int SW   = DW + $clog2(N);
  localparam int MAXC = 128;

  logic          clk = 1'b0;
  logic          rst, start, din_valid;
  logic [DW-1:0] max_in, din, exp_out;
  logic          exp_valid, done;
  logic [SW-1:0] sum_out;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] vec_din [N];
  logic [DW-1:0] vec_exp [N];
  int            vec_gap [N];
  int            acc_cyc [N];
  logic          obs_v    [MAXC];
  logic [DW-1:0] obs_x    [MAXC];
  logic          obs_done [MAXC];
  logic [SW-1:0] obs_sum  [MAXC];
  int            ncyc;

  always #5 clk = ~clk;

  exp_sum #(.DW(DW), .N(N), .LUT_BITS(6), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .max_in(max_in), .din(din),
    .din_valid(din_valid), .exp_out(exp_out), .exp_valid(exp_valid),
    .sum_out(sum_out), .done(done)
  );

  task automatic tick();
    @(posedge clk); #1;
    if (ncyc < MAXC) begin
      obs_v[ncyc]    = exp_valid;
      obs_x[ncyc]    = exp_out;
      obs_done[ncyc] = done;
      obs_sum[ncyc]  = sum_out;
    end
    ncyc++;
  endtask

  // Starts a vector, streams vec_din with vec_gap idle cycles before each element,
  // then keeps din_valid high through the drain so stray accepts would show up.
  task automatic run_vector(input logic [DW-1:0] mx, input int extra_start_at);
    for (int c = 0; c < MAXC; c++) begin
      obs_v[c] = 1'b0;
      obs_done[c] = 1'b0;
    end
    ncyc = 0;
    start = 1'b1; max_in = mx; din_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; max_in = 32'h1234_5678;
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < vec_gap[i]; g++) begin
        din_valid = 1'b0; din = $urandom();
        tick();
      end
      din_valid = 1'b1; din = vec_din[i];
      start = (i == extra_start_at);
      acc_cyc[i] = ncyc;
      tick();
      start = 1'b0;
    end
    din = vec_din[0];
    repeat (10) tick();
    din_valid = 1'b0;
  endtask

  function automatic int count_valid();
    int n = 0;
    for (int c = 0; c < ncyc && c < MAXC; c++) if (obs_v[c] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done();
    int n = 0;
    for (int c = 0; c < ncyc && c < MAXC; c++) if (obs_done[c] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0; max_in = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_out !== '0 || exp_valid !== 1'b0 || sum_out !== '0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: exp_out=%h exp_valid=%b sum_out=%h done=%b, required all 0",
               exp_out, exp_valid, sum_out, done);
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      din_valid = c[0]; din = $urandom();
      @(posedge clk); #1;
      vectors++;
      if (exp_valid !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_quiet cyc %0d: exp_valid=%b done=%b, required 0 0", c, exp_valid, done);
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_equal_max();
    for (int i = 0; i < N; i++) begin
      vec_din[i] = 32'h0003_0000; vec_exp[i] = 32'h0001_0000; vec_gap[i] = 0;
    end
    run_vector(32'h0003_0000, -1);
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (obs_v[acc_cyc[i]+3] !== 1'b1 || obs_x[acc_cyc[i]+3] !== vec_exp[i]) begin
        miscompares++;
        $display("FAIL eqmax elem %0d: valid=%b exp_out=%h, required valid=1 exp_out=%h",
                 i, obs_v[acc_cyc[i]+3], obs_x[acc_cyc[i]+3], vec_exp[i]);
      end
    end
    vectors++;
    if (count_valid() != N) begin
      miscompares++;
      $display("FAIL eqmax valid_count: got %0d, required %0d", count_valid(), N);
    end
    vectors++;
    if (obs_done[acc_cyc[N-1]+3] !== 1'b0 || obs_done[acc_cyc[N-1]+4] !== 1'b1 || count_done() != 1) begin
      miscompares++;
      $display("FAIL eqmax done_timing: done@+3=%b done@+4=%b pulses=%0d, required 0 1 1",
               obs_done[acc_cyc[N-1]+3], obs_done[acc_cyc[N-1]+4], count_done());
    end
    vectors++;
    if (obs_sum[ncyc-1] !== 37'h0_0020_0000) begin
      miscompares++;
      $display("FAIL eqmax sum: got %h, required %h", obs_sum[ncyc-1], 37'h0_0020_0000);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sum_out !== 37'h0_0020_0000) begin
      miscompares++;
      $display("FAIL eqmax sum_hold: got %h, required %h", sum_out, 37'h0_0020_0000);
    end
  endtask

  task automatic test_exp_values();
    logic [DW-1:0] d_tbl [7];
    logic [DW-1:0] e_tbl [7];
    // -1.0, -20.0, +1.0 (clamped), -0.5, -2.0, -11.0 (k=16), -12.0 (k=18)
    d_tbl = '{32'hFFFF_0000, 32'hFFEC_0000, 32'h0001_0000, 32'hFFFF_8000,
              32'hFFFE_0000, 32'hFFF5_0000, 32'hFFF4_0000};
    e_tbl = '{32'd23935, 32'd0, 32'd65536, 32'd39392, 32'd8837, 32'd1, 32'd0};
    for (int i = 0; i < N; i++) begin
      vec_din[i] = (i < 7) ? d_tbl[i] : 32'h0;
      vec_exp[i] = (i < 7) ? e_tbl[i] : 32'h0001_0000;
      vec_gap[i] = 0;
    end
    run_vector(32'h0, -1);
    vectors++;
    if (obs_v[acc_cyc[0]+2] !== 1'b0) begin
      miscompares++;
      $display("FAIL expval early_valid: exp_valid=%b two cycles after accept, required 0",
               obs_v[acc_cyc[0]+2]);
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (obs_v[acc_cyc[i]+3] !== 1'b1 || obs_x[acc_cyc[i]+3] !== vec_exp[i]) begin
        miscompares++;
        $display("FAIL expval elem %0d: valid=%b exp_out=%0d, required valid=1 exp_out=%0d",
                 i, obs_v[acc_cyc[i]+3], obs_x[acc_cyc[i]+3], vec_exp[i]);
      end
    end
    vectors++;
    if (count_valid() != N || count_done() != 1 || obs_done[acc_cyc[N-1]+4] !== 1'b1) begin
      miscompares++;
      $display("FAIL expval counts: valid=%0d done=%0d, required %0d 1", count_valid(), count_done(), N);
    end
    vectors++;
    if (obs_sum[ncyc-1] !== 37'd1776101) begin
      miscompares++;
      $display("FAIL expval sum: got %0d, required %0d", obs_sum[ncyc-1], 1776101);
    end
  endtask

  task automatic test_gapped_restart();
    logic [DW-1:0] d_tbl [6];
    logic [DW-1:0] e_tbl [6];
    logic [SW-1:0] want;
    // Max near the top of the range: exercises the wide subtract and the clamp.
    d_tbl = '{32'h7FFE_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 32'h7FFE_8000, 32'h7FFD_0000, 32'h8000_0000};
    e_tbl = '{32'd23935, 32'd65536, 32'd65536, 32'd39392, 32'd8837, 32'd0};
    want = '0;
    for (int i = 0; i < N; i++) begin
      vec_din[i] = d_tbl[i % 6];
      vec_exp[i] = e_tbl[i % 6];
      vec_gap[i] = (i % 2 == 1) ? 2 : 0;
      want += SW'(vec_exp[i]);
    end
    run_vector(32'h7FFF_0000, 5);
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (obs_v[acc_cyc[i]+3] !== 1'b1 || obs_x[acc_cyc[i]+3] !== vec_exp[i]) begin
        miscompares++;
        $display("FAIL gapped elem %0d: valid=%b exp_out=%0d, required valid=1 exp_out=%0d",
                 i, obs_v[acc_cyc[i]+3], obs_x[acc_cyc[i]+3], vec_exp[i]);
      end
    end
    vectors++;
    if (count_valid() != N || count_done() != 1 || obs_done[acc_cyc[N-1]+4] !== 1'b1) begin
      miscompares++;
      $display("FAIL gapped counts: valid=%0d done=%0d, required %0d 1", count_valid(), count_done(), N);
    end
    vectors++;
    if (obs_sum[ncyc-1] !== want) begin
      miscompares++;
      $display("FAIL gapped sum: got %0d, required %0d", obs_sum[ncyc-1], want);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; max_in = '0; din_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din_valid = 1'b1; din = '0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (exp_valid !== 1'b0 || done !== 1'b0 || sum_out !== '0) begin
        miscompares++;
        $display("FAIL abort_quiet cyc %0d: exp_valid=%b done=%b sum_out=%h, required 0 0 0",
                 c, exp_valid, done, sum_out);
      end
    end
    for (int i = 0; i < N; i++) begin
      vec_din[i] = 32'hFFFF_0000; vec_exp[i] = 32'd23935; vec_gap[i] = 0;
    end
    run_vector(32'h0, -1);
    vectors++;
    if (count_valid() != N || count_done() != 1 || obs_done[acc_cyc[N-1]+4] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort counts: valid=%0d done=%0d, required %0d 1", count_valid(), count_done(), N);
    end
    vectors++;
    if (obs_sum[ncyc-1] !== 37'd765920) begin
      miscompares++;
      $display("FAIL abort sum: got %0d, required %0d", obs_sum[ncyc-1], 765920);
    end
  endtask

  initial begin
    test_reset();
    test_equal_max();
    test_exp_values();
    test_gapped_restart();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
